// File: rtl/fetch_sequencer.sv
// nic8 fetch sequencer: PC, IR and FETCH/EXEC/HALT phase control.
// Feeds the control decoder and drives the program ROM address.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [2:0] HALT_DEST = 3'd7
) (
  input  logic       clk,
  input  logic       resetBar,
  input  logic [7:0] dataBus,
  input  logic       doJumpBar,
  input  logic       loadBarIR,
  input  logic       run,
  input  logic       step,
  output logic [7:0] romAddr,
  output logic [7:0] ir,
  output logic       decodeEnable,
  output logic       immFetch,
  output logic       halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic [7:0] pc;
  logic [7:0] pcNext;
  logic [7:0] irQ;
  logic [7:0] irNext;
  logic       adv;
  logic       busHalt;

  assign adv     = run | step;
  assign busHalt = (dataBus[6:4] == HALT_DEST);

  assign romAddr      = pc;
  assign ir           = irQ;
  assign decodeEnable = (state == EXEC);
  assign immFetch     = (state == EXEC) && (irQ[2:0] == 3'b000);
  assign halted       = (state == HALT);

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state <= FETCH;
      pc    <= RESET_PC;
      irQ   <= 8'h00;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      irQ   <= irNext;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    irNext    = irQ;
    unique case (state)
      FETCH: begin
        if (adv) begin
          irNext    = dataBus;
          pcNext    = pc + 8'd1;
          stateNext = busHalt ? HALT : EXEC;
        end
      end
      EXEC: begin
        if (adv) begin
          // a jump wins over consuming an immediate byte
          if (!doJumpBar)
            pcNext = dataBus;
          else if (immFetch)
            pcNext = pc + 8'd1;
          if (!loadBarIR) begin
            irNext    = dataBus;
            stateNext = busHalt ? HALT : EXEC;
          end else begin
            stateNext = FETCH;
          end
        end
      end
      HALT: begin
        stateNext = HALT;
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Inputs change 1ns after each rising edge; outputs sampled there.
module tb_fetch_sequencer;

  logic       clk;
  logic       resetBar;
  logic [7:0] dataBus;
  logic       doJumpBar;
  logic       loadBarIR;
  logic       run;
  logic       step;
  logic [7:0] romAddr;
  logic [7:0] ir;
  logic       decodeEnable;
  logic       immFetch;
  logic       halted;

  int nCmp;
  int nBad;

  fetch_sequencer dut (
    .clk          (clk),
    .resetBar     (resetBar),
    .dataBus      (dataBus),
    .doJumpBar    (doJumpBar),
    .loadBarIR    (loadBarIR),
    .run          (run),
    .step         (step),
    .romAddr      (romAddr),
    .ir           (ir),
    .decodeEnable (decodeEnable),
    .immFetch     (immFetch),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pc, ir, decodeEnable, immFetch, halted in one go
  task automatic chkAll(input string tag,
                        input logic [7:0] ePc,
                        input logic [7:0] eIr,
                        input logic eDe,
                        input logic eImm,
                        input logic eHalt);
    chk({tag, ".pc"},   romAddr, ePc);
    chk({tag, ".ir"},   ir, eIr);
    chk({tag, ".de"},   {7'd0, decodeEnable}, {7'd0, eDe});
    chk({tag, ".imm"},  {7'd0, immFetch}, {7'd0, eImm});
    chk({tag, ".halt"}, {7'd0, halted}, {7'd0, eHalt});
  endtask

  initial begin
    nCmp      = 0;
    nBad      = 0;
    resetBar  = 1'b0;
    run       = 1'b0;
    step      = 1'b0;
    doJumpBar = 1'b1;
    loadBarIR = 1'b1;
    dataBus   = 8'h00;
    #2;
    chkAll("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    resetBar = 1'b1;
    run      = 1'b1;

    // 1: immediate load A <- ROM
    dataBus = 8'h20;
    tick();
    chkAll("t1f", 8'h01, 8'h20, 1'b1, 1'b1, 1'b0);
    dataBus = 8'h05;
    tick();
    chkAll("t1e", 8'h02, 8'h20, 1'b0, 1'b0, 1'b0);

    // 2: register-sourced op holds pc
    dataBus = 8'h22;
    tick();
    chkAll("t2f", 8'h03, 8'h22, 1'b1, 1'b0, 1'b0);
    dataBus = 8'h99;
    tick();
    chkAll("t2e", 8'h03, 8'h22, 1'b0, 1'b0, 1'b0);

    // 3: jump taken, then not taken
    dataBus = 8'h10;
    tick();
    chkAll("t3f", 8'h04, 8'h10, 1'b1, 1'b1, 1'b0);
    dataBus   = 8'h40;
    doJumpBar = 1'b0;
    tick();
    chkAll("t3j", 8'h40, 8'h10, 1'b0, 1'b0, 1'b0);
    doJumpBar = 1'b1;
    dataBus   = 8'h10;
    tick();
    chk("t3f2.pc", romAddr, 8'h41);
    dataBus = 8'h40;
    tick();
    chk("t3nj.pc", romAddr, 8'h42);

    // 4: IR-load chain skips FETCH
    dataBus = 8'h21;
    tick();
    chkAll("t4f", 8'h43, 8'h21, 1'b1, 1'b0, 1'b0);
    dataBus   = 8'h22;
    loadBarIR = 1'b0;
    tick();
    chkAll("t4l", 8'h43, 8'h22, 1'b1, 1'b0, 1'b0);
    loadBarIR = 1'b1;
    dataBus   = 8'h00;
    tick();
    chkAll("t4e", 8'h43, 8'h22, 1'b0, 1'b0, 1'b0);

    // 5: jump to FF, fetch halt byte, wrap
    dataBus = 8'h10;
    tick();
    chk("t5f.pc", romAddr, 8'h44);
    dataBus   = 8'hFF;
    doJumpBar = 1'b0;
    tick();
    chk("t5j.pc", romAddr, 8'hFF);
    doJumpBar = 1'b1;
    dataBus   = 8'h70;
    tick();
    chkAll("t5h", 8'h00, 8'h70, 1'b0, 1'b0, 1'b1);
    dataBus   = 8'h3C;
    doJumpBar = 1'b0;
    loadBarIR = 1'b0;
    step      = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chkAll("t5hold", 8'h00, 8'h70, 1'b0, 1'b0, 1'b1);
    step      = 1'b0;
    doJumpBar = 1'b1;
    loadBarIR = 1'b1;
    resetBar  = 1'b0;
    #2;
    chkAll("t5rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    resetBar = 1'b1;
    run      = 1'b0;

    // 6: single-step
    dataBus = 8'h33;
    for (int i = 0; i < 10; i++) tick();
    chkAll("t6idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chkAll("t6step", 8'h01, 8'h33, 1'b1, 1'b0, 1'b0);
    dataBus   = 8'h80;
    doJumpBar = 1'b0;
    tick();
    chkAll("t6hold", 8'h01, 8'h33, 1'b1, 1'b0, 1'b0);
    resetBar = 1'b0;
    #2;
    chkAll("t6rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    resetBar  = 1'b1;
    doJumpBar = 1'b1;
    run       = 1'b1;
    dataBus   = 8'h01;
    tick();
    chkAll("t6refetch", 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
